pwm_duty_ramp: RTL and testbench

Upstream control stage for the three-phase pwm block. It drives that block's duty_cycle and en inputs.
- Accepts a target duty over a valid/ready handshake.
- Slews duty_cycle toward the target in fixed steps, changing it only at PWM period boundaries.
- Soft-starts from 0 on run and ramps down to 0 before dropping en on stop.

---
 rtl/pwm_duty_ramp_pkg.sv | 14 +
 rtl/pwm_duty_ramp_timer.sv | 42 ++++
 rtl/pwm_duty_ramp.sv | 104 ++++++++++
 tb/tb_pwm_duty_ramp.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_ramp_pkg.sv
// Shared types and defaults for the PWM duty ramp controller.
// Imported by the ramp top and its period timer.
package pwm_duty_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK    = 2'd1,
        STOPPING = 2'd2
    } ramp_state_t;

    localparam int PWM_PERIOD = 256;
    localparam int DUTY_WIDTH = 8;

endpackage

// File: rtl/pwm_duty_ramp_timer.sv
// Period and step-period counters; both held at zero while en is low,
// so they start in lockstep with the downstream PWM counter.
module pwm_period_timer
    import pwm_duty_ramp_pkg::*;
#(
    parameter int PERIOD       = PWM_PERIOD,
    parameter int RAMP_PERIODS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic period_tick,
    output logic step
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
    localparam logic [SW-1:0] S_LAST = SW'(RAMP_PERIODS - 1);

    logic [PW-1:0] pcnt;
    logic [SW-1:0] scnt;

    assign period_tick = en && (pcnt == P_LAST);
    assign step        = period_tick && (scnt == S_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            scnt <= '0;
        end else if (!en) begin
            pcnt <= '0;
            scnt <= '0;
        end else begin
            pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
            if (period_tick) begin
                scnt <= (scnt == S_LAST) ? '0 : scnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty slew controller feeding the three-phase PWM block: soft start,
// period-aligned ramping toward a handshaken target, and ramp-down stop.
module pwm_duty_ramp
    import pwm_duty_ramp_pkg::*;
#(
    parameter int DUTY_W       = DUTY_WIDTH,
    parameter int PERIOD       = PWM_PERIOD,
    parameter int RAMP_STEP    = 4,
    parameter int RAMP_PERIODS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              tgt_valid,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ready,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              en,
    output logic              period_tick,
    output logic              at_target,
    output logic              busy
);

    localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(RAMP_STEP);

    ramp_state_t       state;
    ramp_state_t       state_next;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] dest;
    logic [DUTY_W-1:0] duty_step;
    logic [DUTY_W:0]   d_ext;
    logic [DUTY_W:0]   t_ext;
    logic              step;

    pwm_period_timer #(
        .PERIOD       (PERIOD),
        .RAMP_PERIODS (RAMP_PERIODS)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .period_tick (period_tick),
        .step        (step)
    );

    assign en        = (state != IDLE);
    assign busy      = (state != IDLE);
    assign tgt_ready = (state != STOPPING);
    assign at_target = (state == TRACK) && (duty_cycle == target);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (run) state_next = TRACK;
            end
            TRACK: begin
                if (!run) state_next = STOPPING;
            end
            STOPPING: begin
                if (run) begin
                    state_next = TRACK;
                end else if (step && duty_cycle == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Widened compare/add so a step clamps at dest instead of wrapping.
    always_comb begin
        dest      = (state == TRACK) ? target : '0;
        d_ext     = {1'b0, duty_cycle};
        t_ext     = {1'b0, dest};
        duty_step = dest;
        if (t_ext > d_ext) begin
            if (t_ext - d_ext > STEP_X) begin
                duty_step = DUTY_W'(d_ext + STEP_X);
            end
        end else if (d_ext - t_ext > STEP_X) begin
            duty_step = DUTY_W'(d_ext - STEP_X);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= '0;
            target     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                duty_cycle <= '0;
            end else if (step) begin
                duty_cycle <= duty_step;
            end
            if (tgt_valid && tgt_ready) begin
                target <= tgt_duty;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: vector table, directed corner sequences and
// random stimulus against a per-cycle arithmetic reference model.
module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [7:0] tgt_duty = 8'd0;

    logic       tgt_ready, en, period_tick, at_target, busy;
    logic [7:0] duty_cycle;
    logic       tgt_ready3, en3, period_tick3, at_target3, busy3;
    logic [7:0] duty_cycle3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .tgt_valid   (tgt_valid),
        .tgt_duty    (tgt_duty),
        .tgt_ready   (tgt_ready),
        .duty_cycle  (duty_cycle),
        .en          (en),
        .period_tick (period_tick),
        .at_target   (at_target),
        .busy        (busy)
    );

    pwm_duty_ramp #(.RAMP_PERIODS(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .tgt_valid   (tgt_valid),
        .tgt_duty    (tgt_duty),
        .tgt_ready   (tgt_ready3),
        .duty_cycle  (duty_cycle3),
        .en          (en3),
        .period_tick (period_tick3),
        .at_target   (at_target3),
        .busy        (busy3)
    );

    // Reference model: 0=idle 1=track 2=stopping; m_t = clocks since en rose.
    int m_st[2];
    int m_duty[2];
    int m_tgt[2];
    int m_t[2];

    function automatic int rp(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_duty[i] = 0; m_tgt[i] = 0; m_t[i] = 0;
        end
    endfunction

    function automatic bit m_tick(input int i);
        return (m_st[i] != 0) && (m_t[i] % 256 == 255);
    endfunction

    function automatic void m_clock();
        for (int i = 0; i < 2; i++) begin
            int  len, dest, nd, ns, diff;
            bit  act, stp;
            len  = 256 * rp(i);
            act  = (m_st[i] != 0);
            stp  = act && (m_t[i] % len == len - 1);
            dest = (m_st[i] == 1) ? m_tgt[i] : 0;
            nd   = m_duty[i];
            if (stp) begin
                diff = dest - nd;
                if (diff > 4) nd = nd + 4;
                else if (diff < -4) nd = nd - 4;
                else nd = dest;
            end
            ns = m_st[i];
            if (m_st[i] == 0 && run) ns = 1;
            else if (m_st[i] == 1 && !run) ns = 2;
            else if (m_st[i] == 2) begin
                if (run) ns = 1;
                else if (stp && m_duty[i] == 0) ns = 0;
            end
            if (tgt_valid && m_st[i] != 2) m_tgt[i] = int'(tgt_duty);
            m_t[i]    = (ns == 0 || !act) ? 0 : m_t[i] + 1;
            m_duty[i] = (m_st[i] == 0) ? 0 : nd;
            m_st[i]   = ns;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        for (int i = 0; i < 2; i++) begin
            logic [12:0] e, a;
            e = {m_duty[i][7:0], m_st[i] != 0, m_tick(i),
                 m_st[i] == 1 && m_duty[i] == m_tgt[i], m_st[i] != 0, m_st[i] != 2};
            if (i == 0) a = {duty_cycle, en, period_tick, at_target, busy, tgt_ready};
            else a = {duty_cycle3, en3, period_tick3, at_target3, busy3, tgt_ready3};
            chk(i == 0 ? "model rp1 {duty,en,tick,at,busy,rdy}"
                       : "model rp3 {duty,en,tick,at,busy,rdy}", 32'(a), 32'(e));
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        if (!rst) m_clock();
        #1;
        cmp_model();
    endtask

    // Asserts rst between clock edges and checks outputs before any edge.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst duty", 32'(duty_cycle), 32'd0);
        chk("rst en", 32'(en), 32'd0);
        chk("rst tick", 32'(period_tick), 32'd0);
        chk("rst at_target", 32'(at_target), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(tgt_ready), 32'd1);
        chk("rst duty rp3", 32'(duty_cycle3), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_step();
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 600 && !hit; k++) begin
            hit = m_tick(0);
            step_cycle();
        end
        chk("step seen within bound", 32'(hit), 32'd1);
    endtask

    task automatic wait_tick_cycle();
        int k;
        k = 0;
        while (!m_tick(0) && k < 600) begin
            step_cycle();
            k++;
        end
        chk("tick cycle reached", 32'(m_tick(0)), 32'd1);
    endtask

    typedef struct {
        int run; int valid; int tgt; int n;
        int duty; int en; int at; int busy; int ready;
    } vec_t;

    vec_t tv[20];

    initial begin
        tv = '{
            '{1, 1, 20, 1,   0,  1, 0, 1, 1},
            '{1, 0, 0,  256, 4,  1, 0, 1, 1},
            '{1, 0, 0,  256, 8,  1, 0, 1, 1},
            '{1, 0, 0,  256, 12, 1, 0, 1, 1},
            '{1, 0, 0,  256, 16, 1, 0, 1, 1},
            '{1, 0, 0,  256, 20, 1, 1, 1, 1},
            '{1, 1, 10, 1,   20, 1, 0, 1, 1},
            '{1, 0, 0,  255, 16, 1, 0, 1, 1},
            '{1, 0, 0,  256, 12, 1, 0, 1, 1},
            '{1, 0, 0,  256, 10, 1, 1, 1, 1},
            '{1, 0, 0,  256, 10, 1, 1, 1, 1},
            '{0, 0, 0,  1,   10, 1, 0, 1, 0},
            '{0, 1, 99, 255, 6,  1, 0, 1, 0},
            '{0, 1, 99, 256, 2,  1, 0, 1, 0},
            '{0, 1, 99, 256, 0,  1, 0, 1, 0},
            '{0, 1, 99, 256, 0,  0, 0, 0, 1},
            '{1, 0, 0,  1,   0,  1, 0, 1, 1},
            '{1, 0, 0,  256, 4,  1, 0, 1, 1},
            '{1, 0, 0,  256, 8,  1, 0, 1, 1},
            '{1, 0, 0,  256, 10, 1, 1, 1, 1}
        };
        m_reset();
        do_reset();

        for (int i = 0; i < 20; i++) begin
            run       = tv[i].run[0];
            tgt_valid = tv[i].valid[0];
            tgt_duty  = 8'(tv[i].tgt);
            repeat (tv[i].n) step_cycle();
            chk($sformatf("vec%0d duty", i), 32'(duty_cycle), 32'(tv[i].duty));
            chk($sformatf("vec%0d en", i), 32'(en), 32'(tv[i].en));
            chk($sformatf("vec%0d at_target", i), 32'(at_target), 32'(tv[i].at));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].busy));
            chk($sformatf("vec%0d ready", i), 32'(tgt_ready), 32'(tv[i].ready));
        end

        // Async reset mid-ramp at duty 100, slow instance steps every 768 clocks.
        run = 1'b0; tgt_valid = 1'b0;
        do_reset();
        run = 1'b1; tgt_valid = 1'b1; tgt_duty = 8'd200;
        step_cycle();
        tgt_valid = 1'b0;
        repeat (767) step_cycle();
        chk("rp3 duty before first step", 32'(duty_cycle3), 32'd0);
        step_cycle();
        chk("rp3 duty after 768 clocks", 32'(duty_cycle3), 32'd4);
        repeat (5632) step_cycle();
        chk("ramp duty 100", 32'(duty_cycle), 32'd100);
        chk("rp3 duty after 8 steps", 32'(duty_cycle3), 32'd32);
        repeat (10) step_cycle();
        do_reset();

        // Saturation at the top: 250 then 255, no wrap.
        tgt_valid = 1'b1; tgt_duty = 8'd250;
        step_cycle();
        tgt_valid = 1'b0;
        repeat (63) wait_step();
        chk("top duty 250", 32'(duty_cycle), 32'd250);
        chk("top at_target", 32'(at_target), 32'd1);
        tgt_valid = 1'b1; tgt_duty = 8'd255;
        step_cycle();
        tgt_valid = 1'b0;
        wait_step();
        chk("top duty 254", 32'(duty_cycle), 32'd254);
        wait_step();
        chk("top duty 255", 32'(duty_cycle), 32'd255);
        wait_step();
        chk("top duty holds 255", 32'(duty_cycle), 32'd255);

        // Retarget down, with the handshake landing on a tick cycle.
        run = 1'b0;
        do_reset();
        run = 1'b1; tgt_valid = 1'b1; tgt_duty = 8'd40;
        step_cycle();
        tgt_valid = 1'b0;
        repeat (10) wait_step();
        chk("retarget duty 40", 32'(duty_cycle), 32'd40);
        wait_tick_cycle();
        tgt_valid = 1'b1; tgt_duty = 8'd30;
        step_cycle();
        tgt_valid = 1'b0;
        chk("tick handshake uses old target", 32'(duty_cycle), 32'd40);
        wait_step();
        chk("retarget 36", 32'(duty_cycle), 32'd36);
        wait_step();
        chk("retarget 32", 32'(duty_cycle), 32'd32);
        wait_step();
        chk("retarget 30", 32'(duty_cycle), 32'd30);

        // Stop abort: back to TRACK from 12 and climb to 16.
        tgt_valid = 1'b1; tgt_duty = 8'd16;
        step_cycle();
        tgt_valid = 1'b0;
        repeat (4) wait_step();
        chk("abort start 16", 32'(duty_cycle), 32'd16);
        run = 1'b0;
        step_cycle();
        chk("abort stopping ready", 32'(tgt_ready), 32'd0);
        wait_step();
        chk("abort duty 12", 32'(duty_cycle), 32'd12);
        run = 1'b1;
        step_cycle();
        chk("abort track ready", 32'(tgt_ready), 32'd1);
        chk("abort duty kept", 32'(duty_cycle), 32'd12);
        wait_step();
        chk("abort climb 16", 32'(duty_cycle), 32'd16);
        chk("abort at_target", 32'(at_target), 32'd1);

        // Random run/target traffic against the model.
        do_reset();
        for (int c = 0; c < 12000; c++) begin
            if ($urandom_range(0, 399) == 0) run = ~run;
            tgt_valid = ($urandom_range(0, 19) == 0);
            tgt_duty  = 8'($urandom);
            step_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
